rv_mem_uart_bus: RTL and testbench

// - Memory/peripheral subsystem directly downstream of the ice-risc RV core; consumes its two read

---
 rtl/rv_mem_uart_bus.sv | 167 ++++++++++++++++
 tb/tb_rv_mem_uart_bus.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_uart_bus.sv
// Word RAM with byte strobes plus an MMIO 8N1 UART transmitter fed by a small TX FIFO.
// Optional feature: define RV_UART_OVFCNT_EN for a saturating dropped-push counter at UART_BASE+8.
module rv_mem_uart_bus #(
    parameter int unsigned RAM_AW    = 10,
    parameter int unsigned FIFO_AW   = 2,
    parameter int unsigned BAUD_DIV  = 868,
    parameter logic [31:0] UART_BASE = 32'hFFFF_FFF0
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic [31:0] iwRead1Addr,
    input  logic [31:0] iwRead2Addr,
    input  logic [31:0] iwWriteAddr,
    input  logic [31:0] iwWriteData,
    input  logic [3:0]  iwWstrb,
    output logic [31:0] owRead1Data,
    output logic [31:0] owRead2Data,
    output logic        owTx
);

    localparam int unsigned CntW  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned Depth = 2 ** FIFO_AW;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    logic [31:0]      ram_q [2 ** RAM_AW];
    logic [7:0]       fifo_q [Depth];
    logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
    tx_state_e        state_q;
    logic [CntW-1:0]  cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;

    logic        rd1_mmio, rd2_mmio, wr_mmio;
    logic        fifo_empty, fifo_full, busy;
    logic        push_req, push_ok, pop, cnt_end;
    logic [31:0] ovf_word;
    logic [31:0] mmio_word [4];
    logic        unused_addr;

    assign rd1_mmio = (iwRead1Addr[31:4] == UART_BASE[31:4]);
    assign rd2_mmio = (iwRead2Addr[31:4] == UART_BASE[31:4]);
    assign wr_mmio  = (iwWriteAddr[31:4] == UART_BASE[31:4]);

    assign unused_addr = ^{iwRead1Addr[1:0], iwRead2Addr[1:0], iwWriteAddr[1:0]};

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {FIFO_AW{1'b0}}});
    assign busy       = (state_q != StIdle);
    assign cnt_end    = (cnt_q == CntW'(BAUD_DIV - 1));

    assign push_req = wr_mmio && (iwWriteAddr[3:2] == 2'd0) && iwWstrb[0];
    // Fullness is judged before the edge; a pop in the same cycle does not make room.
    assign push_ok  = push_req && !fifo_full;
    assign pop      = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && cnt_end));

    assign mmio_word[0] = '0;
    assign mmio_word[1] = {29'b0, fifo_empty, busy, fifo_full};
    assign mmio_word[2] = ovf_word;
    assign mmio_word[3] = '0;

    assign owRead1Data = rd1_mmio ? mmio_word[iwRead1Addr[3:2]] : ram_q[iwRead1Addr[RAM_AW+1:2]];
    assign owRead2Data = rd2_mmio ? mmio_word[iwRead2Addr[3:2]] : ram_q[iwRead2Addr[RAM_AW+1:2]];
    assign owTx        = tx_q;

    always_ff @(posedge iwClk) begin
        if (!wr_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (iwWstrb[i]) ram_q[iwWriteAddr[RAM_AW+1:2]][8*i +: 8] <= iwWriteData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge iwClk) begin
        if (push_ok && !iwRst) fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= iwWriteData[7:0];
    end

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            wr_ptr_q <= '0;
        end else if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

`ifdef RV_UART_OVFCNT_EN
    logic [15:0] ovf_q;

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            ovf_q <= '0;
        end else if (push_req && fifo_full && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign ovf_word = {16'b0, ovf_q};
`else
    assign ovf_word = '0;
`endif

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            rd_ptr_q <= '0;
        end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q <= fifo_q[rd_ptr_q[FIFO_AW-1:0]];
                        cnt_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_end) begin
                        cnt_q <= '0;
                        // Back-to-back frames: go straight to the next start bit.
                        if (pop) begin
                            shift_q <= fifo_q[rd_ptr_q[FIFO_AW-1:0]];
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_uart_bus.sv
// Bench for rv_mem_uart_bus: directed vector table, multi-cycle UART sequences and a randomized
// run checked against a byte-queue / frame-position model of the subsystem.
module tb_rv_mem_uart_bus;

    localparam int unsigned BAUD  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * BAUD;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] r1, r2, wa, wd;
    logic [3:0]  ws;
    logic [31:0] rd1, rd2;
    logic        tx;

    rv_mem_uart_bus #(
        .RAM_AW   (10),
        .FIFO_AW  (2),
        .BAUD_DIV (BAUD),
        .UART_BASE(BASE)
    ) dut (
        .iwClk      (clk),
        .iwRst      (rst),
        .iwRead1Addr(r1),
        .iwRead2Addr(r2),
        .iwWriteAddr(wa),
        .iwWriteData(wd),
        .iwWstrb    (ws),
        .owRead1Data(rd1),
        .owRead2Data(rd2),
        .owTx       (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes waiting, whether a frame is on the wire and how far into it.
    logic [7:0]  m_q[$];
    logic        m_active = 1'b0;
    int          m_pos    = 0;
    logic [7:0]  m_cur    = '0;
    int          m_ovf    = 0;
    logic [31:0] ram_m [1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_mmio(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / BAUD;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [31:0] ovf;
        if (is_mmio(a)) begin
`ifdef RV_UART_OVFCNT_EN
            ovf = 32'(m_ovf);
`else
            ovf = 32'd0;
`endif
            case (a[3:2])
                2'd1:    return {29'b0, m_q.size() == 0, m_active, m_q.size() == DEPTH};
                2'd2:    return ovf;
                default: return 32'd0;
            endcase
        end
        return ram_m[a[11:2]];
    endfunction

    task automatic model_edge();
        logic full_b;
        logic push;
        if (!is_mmio(wa)) begin
            for (int i = 0; i < 4; i++) if (ws[i]) ram_m[wa[11:2]][8*i +: 8] = wd[8*i +: 8];
        end
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 0;
            return;
        end
        full_b = (m_q.size() == DEPTH);
        push   = is_mmio(wa) && (wa[3:2] == 2'd0) && ws[0];
        if (!m_active) begin
            if (m_q.size() != 0) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME) begin
                if (m_q.size() != 0) begin
                    m_cur = m_q.pop_front();
                    m_pos = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end
        if (push) begin
            if (!full_b) m_q.push_back(wd[7:0]);
            else if (m_ovf < 65535) m_ovf++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("owTx", {31'b0, tx}, {31'b0, exp_tx()});
    endtask

    task automatic no_write();
        ws = 4'h0;
        wa = 32'h0;
        wd = 32'h0;
    endtask

    task automatic rd_both(input logic [31:0] a1, input logic [31:0] a2);
        r1 = a1;
        r2 = a2;
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 3) == 0) return BASE | 32'($urandom_range(0, 15));
        a        = $urandom;
        a[11:2]  = 10'($urandom_range(0, 63));
        return a;
    endfunction

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [7:0]  b55;
        logic [31:0] exp_ovf;
        int          busy_cnt;
        logic        exp_bit;

        vecs[0] = '{32'h0000_0040, 32'h1122_3344, 4'hF, 32'h0000_0040, 32'h1122_3344};
        vecs[1] = '{32'h0000_0040, 32'hAABB_CCDD, 4'h5, 32'h0000_0040, 32'h11BB_33DD};
        vecs[2] = '{32'h0000_0044, 32'hDEAD_BEEF, 4'hF, 32'h0000_1044, 32'hDEAD_BEEF};
        vecs[3] = '{32'h0000_0047, 32'h0000_00A5, 4'h1, 32'h0000_0044, 32'hDEAD_BEA5};
        vecs[4] = '{32'h8000_0044, 32'h1234_5678, 4'h8, 32'h0000_0046, 32'h12AD_BEA5};
        vecs[5] = '{32'hFFFF_FFF4, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFF4, 32'h0000_0004};
        vecs[6] = '{32'h0000_0040, 32'h0000_0000, 4'h0, 32'h0000_0040, 32'h11BB_33DD};
        vecs[7] = '{32'hFFFF_FFF0, 32'h0000_0041, 4'hE, 32'hFFFF_FFF4, 32'h0000_0004};
        vecs[8] = '{32'hFFFF_FFF8, 32'h0000_0001, 4'hF, 32'hFFFF_FFF8, 32'h0000_0000};
        vecs[9] = '{32'h0000_3FFC, 32'h0BAD_CAFE, 4'hF, 32'h0000_0FFC, 32'h0BAD_CAFE};

        rst = 1'b1;
        r1  = 32'h0;
        r2  = 32'h0;
        no_write();
        step();
        step();
        rst = 1'b0;
        check("reset_tx", {31'b0, tx}, 32'd1);
        rd_both(BASE + 32'd4, BASE + 32'd4);
        check("reset_status1", rd1, 32'h4);
        check("reset_status2", rd2, 32'h4);
        rd_both(BASE + 32'd8, BASE);
        check("reset_ovfcnt", rd1, 32'h0);
        check("reset_txdata", rd2, 32'h0);

        // Directed vector table: write, then read back on both ports after the edge.
        for (int i = 0; i < 10; i++) begin
            wa = vecs[i].waddr;
            wd = vecs[i].wdata;
            ws = vecs[i].strb;
            step();
            no_write();
            rd_both(vecs[i].raddr, vecs[i].raddr);
            check($sformatf("vec%0d_p1", i), rd1, vecs[i].exp);
            check($sformatf("vec%0d_p2", i), rd2, vecs[i].exp);
        end
        step();
        step();
        check("strb1110_tx_idle", {31'b0, tx}, 32'd1);

        // Same-address read and write in one cycle returns the old word.
        wa = 32'h80; wd = 32'h0102_0304; ws = 4'hF;
        step();
        wd = 32'hCAFE_F00D;
        rd_both(32'h80, 32'h80);
        check("rw_same_old", rd1, 32'h0102_0304);
        step();
        no_write();
        rd_both(32'h80, 32'h80);
        check("rw_same_new", rd2, 32'hCAFE_F00D);

        // Single 0x55 frame.
        b55 = 8'h55;
        wa = BASE; wd = {24'h0, b55}; ws = 4'h1;
        step();
        no_write();
        for (int k = 0; k < int'(FRAME); k++) begin
            step();
            if (k < int'(BAUD)) exp_bit = 1'b0;
            else if (k >= 9 * int'(BAUD)) exp_bit = 1'b1;
            else exp_bit = b55[(k - int'(BAUD)) / int'(BAUD)];
            check($sformatf("frame55_bit%0d", k), {31'b0, tx}, {31'b0, exp_bit});
            rd_both(BASE + 32'd4, 32'h40);
            check("frame55_busy", {31'b0, rd1[1]}, 32'd1);
        end
        step();
        rd_both(BASE + 32'd4, BASE + 32'd4);
        check("frame55_done_status", rd1, 32'h4);

        // Six back-to-back pushes into a depth-4 FIFO: one pops at once, one is dropped.
        busy_cnt = 0;
        r2 = BASE + 32'd4;
        for (int i = 0; i < 6; i++) begin
            wa = BASE; wd = 32'hA1 + 32'(i); ws = 4'h1;
            step();
            busy_cnt += int'(rd2[1]);
        end
        no_write();
        rd_both(BASE + 32'd8, BASE + 32'd4);
`ifdef RV_UART_OVFCNT_EN
        exp_ovf = 32'd1;
`else
        exp_ovf = 32'd0;
`endif
        check("burst_ovfcnt", rd1, exp_ovf);
        check("burst_status_full", rd2, 32'h3);
        for (int i = 0; i < 5 * int'(FRAME) + 5; i++) begin
            step();
            rd_both(BASE + 32'd8, BASE + 32'd4);
            check("burst_model_status", rd2, mread(BASE + 32'd4));
            busy_cnt += int'(rd2[1]);
        end
        check("burst_busy_cycles", 32'(busy_cnt), 32'(5 * FRAME));
        check("burst_done_status", rd2, 32'h4);

        // Reset mid-DATA, with a push in the reset cycle.
        wa = BASE; wd = 32'h3C; ws = 4'h1;
        step();
        no_write();
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        wa = BASE; wd = 32'h99; ws = 4'h1;
        step();
        rst = 1'b0;
        no_write();
        check("rst_mid_tx", {31'b0, tx}, 32'd1);
        rd_both(BASE + 32'd4, 32'h40);
        check("rst_mid_status", rd1, 32'h4);
        check("rst_mid_ram", rd2, 32'h11BB_33DD);
        rd_both(BASE + 32'd8, BASE + 32'd4);
        check("rst_mid_ovfcnt", rd1, 32'h0);
        step();
        check("rst_push_dropped_tx", {31'b0, tx}, 32'd1);
        rd_both(BASE + 32'd4, BASE + 32'd4);
        check("rst_push_dropped_status", rd2, 32'h4);

        // Randomized traffic against the model; reads are checked before each edge.
        for (int i = 0; i < 64; i++) begin
            wa = 32'(i * 4); wd = $urandom; ws = 4'hF;
            step();
        end
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    wa = rand_addr();
                    if (is_mmio(wa)) wa = 32'(i % 64) * 32'd4;
                    wd = $urandom;
                    ws = 4'($urandom);
                end
                6, 7: begin
                    wa = BASE | 32'($urandom_range(0, 15));
                    wd = $urandom;
                    ws = 4'($urandom);
                end
                default: no_write();
            endcase
            rd_both(rand_addr(), rand_addr());
            check("rand_rd1", rd1, mread(r1));
            check("rand_rd2", rd2, mread(r2));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
